// File: rtl/i2c_target.sv
// i2c_target -- I2C target (slave) endpoint on split tri-state pins.
//
// Decodes START/STOP, matches a 7-bit address and ACKs it. Bytes written by
// the initiator leave as a one-cycle rx_vld strobe. Bytes read by the
// initiator come from a tx_data/tx_vld source that is popped with tx_rd.
//
// Build option:
//   I2C_TARGET_CLK_STRETCH_EN  If defined, the block holds SCL low at READ
//                              entry while tx_vld=0. If undefined, it
//                              returns 8'hFF instead and SCL is never driven.
//
// Parameters:
//   ADDR         7-bit target address.
//   SYNC_STAGES  Synchronizer depth on SCL/SDA inputs (2..4).
//   HOLD_CYCLES  clk cycles from a sampled SCL fall to an SDA change (1..255).
//
// Ports:
//   clk, rst             system clock; async active-high reset
//   i2c_scl_i/_o/_t      SCL level in, drive value (0), pull-low enable
//   i2c_sda_i/_o/_t      SDA level in, drive value (0), pull-low enable
//   rx_data/rx_vld       written byte and its one-cycle strobe
//   rx_first             with rx_vld: first data byte after (re)START
//   tx_data/tx_vld/tx_rd read byte source; tx_rd strobes on consume
//   busy                 addressed transaction in progress
//   stop_det             one-cycle strobe on any STOP
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_t,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rd,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_rise_s;
  logic                   scl_fall_s;
  logic                   start_s;
  logic                   stop_s;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   rw_r;
  logic                   first_r;
  logic [7:0]             hold_cnt_r;
  logic                   sda_pend_r;
  logic                   sda_pend_s;
  logic                   sda_t_r;
  logic [7:0]             rx_data_r;
  logic                   rx_vld_r;
  logic                   rx_first_r;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   stop_det_r;
  logic                   byte_end_s;
  logic                   addr_hit_s;
  logic                   entry_s;
  logic                   pend_load_s;
  logic                   late_load_s;
  logic                   load_s;
  logic                   load_pend_s;
  logic                   scl_t_s;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // START/STOP need SCL high on both sides of the SDA edge.
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  assign byte_end_s = scl_rise_s & (bit_cnt_r == 3'd7);
  // The 8th address bit is still on sda_s, so bits[7:1] sit in shift_r[6:0].
  assign addr_hit_s = (shift_r[6:0] == ADDR);
  // READ is entered after the address ACK of a read, or on an initiator ACK.
  assign entry_s    = scl_rise_s & (((state_r == ST_ADDR_ACK) & rw_r) |
                                    ((state_r == ST_READ_ACK) & ~sda_s));
  // A deferred load (stretch build only) completes once tx_vld shows up.
  assign pend_load_s = (state_r == ST_READ) & load_pend_s & tx_vld;
  // Deferred load after the first bit slot opened: bit 7 goes out right away.
  assign late_load_s = pend_load_s & (scl_fall_s | scl_t_s);
  assign load_s      = (entry_s & tx_vld) | pend_load_s;

`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic scl_t_r;
  logic load_pend_r;

  // Underflow tracking and SCL stretch control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_t_r     <= 1'b0;
      load_pend_r <= 1'b0;
    end else if (start_s | stop_s) begin
      scl_t_r     <= 1'b0;
      load_pend_r <= 1'b0;
    end else begin
      if (entry_s & ~tx_vld) begin
        load_pend_r <= 1'b1;
      end else if (pend_load_s) begin
        load_pend_r <= 1'b0;
      end else begin
        load_pend_r <= load_pend_r;
      end
      if (scl_fall_s & (state_r == ST_READ) & load_pend_r & ~tx_vld) begin
        scl_t_r <= 1'b1;
      end else if (scl_t_r & ~load_pend_r & (hold_cnt_r == 8'd1)) begin
        // Release together with the hold-timed SDA update after the load.
        scl_t_r <= 1'b0;
      end else begin
        scl_t_r <= scl_t_r;
      end
    end
  end

  assign load_pend_s = load_pend_r;
  assign scl_t_s     = scl_t_r;
`else
  assign load_pend_s = 1'b0;
  assign scl_t_s     = 1'b0;
`endif

  // Input synchronizers and edge-detect flops, preset to an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i2c_scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i2c_sda_i};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; START/STOP override every state.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = ST_ADDR;
    end else if (stop_s) begin
      state_nxt_s = ST_IDLE;
    end else if (scl_rise_s) begin
      case (state_r)
        ST_ADDR: begin
          if (byte_end_s) begin
            state_nxt_s = addr_hit_s ? ST_ADDR_ACK : ST_WAIT_STOP;
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        ST_ADDR_ACK:  state_nxt_s = rw_r ? ST_READ : ST_WRITE;
        ST_WRITE: begin
          if (byte_end_s) begin
            state_nxt_s = ST_WRITE_ACK;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end
        ST_WRITE_ACK: state_nxt_s = ST_WRITE;
        ST_READ: begin
          if (byte_end_s) begin
            state_nxt_s = ST_READ_ACK;
          end else begin
            state_nxt_s = ST_READ;
          end
        end
        ST_READ_ACK:  state_nxt_s = sda_s ? ST_WAIT_STOP : ST_READ;
        ST_IDLE:      state_nxt_s = ST_IDLE;
        ST_WAIT_STOP: state_nxt_s = ST_WAIT_STOP;
        default:      state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // busy follows the addressed states of the next FSM state.
  always_comb begin
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_ADDR_ACK, ST_WRITE, ST_WRITE_ACK, ST_READ, ST_READ_ACK: busy_nxt_s = 1'b1;
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // SDA value to apply HOLD_CYCLES after the current SCL fall.
  always_comb begin
    sda_pend_s = 1'b0;
    case (state_r)
      ST_ADDR_ACK, ST_WRITE_ACK: sda_pend_s = 1'b1;
      ST_READ: begin
        if (pend_load_s) begin
          sda_pend_s = ~tx_data[7];
        end else if (load_pend_s) begin
          sda_pend_s = 1'b0;
        end else begin
          sda_pend_s = ~shift_r[7];
        end
      end
      default: sda_pend_s = 1'b0;
    endcase
  end

  // Shift register, bit counter, R/W flag and receive strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      rw_r       <= 1'b0;
      first_r    <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_vld_r   <= 1'b0;
      rx_first_r <= 1'b0;
      busy_r     <= 1'b0;
      stop_det_r <= 1'b0;
    end else begin
      rx_vld_r   <= 1'b0;
      rx_first_r <= 1'b0;
      busy_r     <= busy_nxt_s;
      stop_det_r <= stop_s;
      if (start_s | stop_s) begin
        bit_cnt_r <= 3'd0;
        first_r   <= start_s;
      end else begin
        if ((state_r == ST_ADDR || state_r == ST_WRITE || state_r == ST_READ) && scl_rise_s) begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
        if ((state_r == ST_ADDR) && byte_end_s) begin
          rw_r <= sda_s;
        end else begin
          rw_r <= rw_r;
        end
        if ((state_r == ST_WRITE) && byte_end_s) begin
          rx_data_r  <= {shift_r[6:0], sda_s};
          rx_vld_r   <= 1'b1;
          rx_first_r <= first_r;
          first_r    <= 1'b0;
        end else begin
          first_r    <= first_r;
        end
      end
      // Shift register sources, highest priority first. Underflow without
      // stretching returns all ones (SDA released for every bit).
      if (entry_s) begin
        shift_r <= tx_vld ? tx_data : 8'hFF;
      end else if (late_load_s) begin
        shift_r <= {tx_data[6:0], 1'b0};
      end else if (pend_load_s) begin
        shift_r <= tx_data;
      end else if (scl_rise_s && (state_r == ST_ADDR || state_r == ST_WRITE)) begin
        shift_r <= {shift_r[6:0], sda_s};
      end else if (scl_fall_s && (state_r == ST_READ)) begin
        shift_r <= {shift_r[6:0], 1'b0};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // SDA driver: changes are delayed HOLD_CYCLES after each SCL fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_t_r    <= 1'b0;
      sda_pend_r <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else if (start_s | stop_s) begin
      sda_t_r    <= 1'b0;
      sda_pend_r <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else if (pend_load_s & scl_t_s) begin
      // SCL is held low by us, so bit 7 can go out at once; the counter
      // then times the SCL release.
      sda_t_r    <= ~tx_data[7];
      sda_pend_r <= ~tx_data[7];
      hold_cnt_r <= HOLD_INIT;
    end else if (scl_fall_s) begin
      sda_t_r    <= sda_t_r;
      sda_pend_r <= sda_pend_s;
      hold_cnt_r <= HOLD_INIT;
    end else if (hold_cnt_r != 8'd0) begin
      hold_cnt_r <= hold_cnt_r - 8'd1;
      sda_pend_r <= sda_pend_r;
      if (hold_cnt_r == 8'd1) begin
        sda_t_r <= sda_pend_r;
      end else begin
        sda_t_r <= sda_t_r;
      end
    end else begin
      sda_t_r    <= sda_t_r;
      sda_pend_r <= sda_pend_r;
      hold_cnt_r <= hold_cnt_r;
    end
  end

  assign i2c_scl_o = 1'b0;
  assign i2c_sda_o = 1'b0;
  assign i2c_scl_t = scl_t_s;
  assign i2c_sda_t = sda_t_r;
  assign rx_data   = rx_data_r;
  assign rx_vld    = rx_vld_r;
  assign rx_first  = rx_first_r;
  assign tx_rd     = load_s;
  assign busy      = busy_r;
  assign stop_det  = stop_det_r;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       scl_line;
  logic       sda_line;
  logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
  logic [7:0] rx_data;
  logic       rx_vld, rx_first;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rd, busy, stop_det;

  logic [7:0] tx_q [0:3];
  logic [1:0] tx_idx;
  logic       tx_adv;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int rx_cnt, stop_cnt, tx_rd_cnt, sda_drv_cnt, scl_drv_cnt, busy_cnt;
  logic [7:0] rx_log_d [0:7];
  logic       rx_log_f [0:7];

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either side pulls it low.
  assign scl_line = m_scl & ~i2c_scl_t;
  assign sda_line = m_sda & ~i2c_sda_t;
  assign tx_data  = tx_q[tx_idx];

  i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i2c_scl_i(scl_line), .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
    .i2c_sda_i(sda_line), .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_first(rx_first),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rd(tx_rd),
    .busy(busy), .stop_det(stop_det)
  );

  // Bus monitor: counts strobes and drive cycles, advances the tx source.
  initial begin
    tx_adv = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_adv) begin
        tx_idx = tx_idx + 2'd1;
        tx_adv = 1'b0;
      end
      if (tx_rd === 1'b1) begin
        tx_rd_cnt++;
        tx_adv = 1'b1;
      end
      if (rx_vld === 1'b1) begin
        if (rx_cnt < 8) begin
          rx_log_d[rx_cnt] = rx_data;
          rx_log_f[rx_cnt] = rx_first;
        end
        rx_cnt++;
      end
      if (stop_det === 1'b1) stop_cnt++;
      if (i2c_sda_t === 1'b1) sda_drv_cnt++;
      if (i2c_scl_t === 1'b1) scl_drv_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_cnt = 0; stop_cnt = 0; tx_rd_cnt = 0;
    sda_drv_cnt = 0; scl_drv_cnt = 0; busy_cnt = 0;
  endtask

  task automatic scl_high();
    int n;
    n = 0;
    m_scl = 1'b1;
    #0;
    while (scl_line !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    if (scl_line !== 1'b1) chk("scl_release", 32'(scl_line), 32'd1);
  endtask

  task automatic bit_io(input logic b, output logic s);
    tick(Q); m_sda = b;
    tick(Q); scl_high();
    tick(Q); s = sda_line;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic do_start();
    m_sda = 1'b1; m_scl = 1'b1;
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic do_rstart();
    tick(Q); m_sda = 1'b1;
    tick(Q); scl_high();
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(Q); m_sda = 1'b0;
    tick(Q); scl_high();
    tick(Q); m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, s);
      d = {d[6:0], s};
    end
    bit_io(nack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    logic [3:0] nib;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    tx_q[0] = 8'h00; tx_q[1] = 8'h00; tx_q[2] = 8'h00; tx_q[3] = 8'h00;
    tx_idx = 2'd0; tx_vld = 1'b0;
    clear_mon();
    tick(4);
    chk("rst_sda_t", 32'(i2c_sda_t), 32'd0);
    chk("rst_scl_t", 32'(i2c_scl_t), 32'd0);
    chk("rst_outs", 32'({rx_vld, rx_first, tx_rd, busy, stop_det}), 32'd0);
    chk("rst_const_o", 32'({i2c_scl_o, i2c_sda_o}), 32'd0);
    rst = 1'b0;
    tick(10);

    // Write: A0, 3C, 81
    clear_mon();
    do_start();
    write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
    chk("wr_busy", 32'(busy), 32'd1);
    write_byte(8'h3C, ack); chk("wr_d0_ack", 32'(ack), 32'd1);
    write_byte(8'h81, ack); chk("wr_d1_ack", 32'(ack), 32'd1);
    do_stop(); tick(10);
    chk("wr_rx_cnt", 32'(rx_cnt), 32'd2);
    chk("wr_rx0", 32'({rx_log_f[0], rx_log_d[0]}), 32'h13C);
    chk("wr_rx1", 32'({rx_log_f[1], rx_log_d[1]}), 32'h081);
    chk("wr_stop_cnt", 32'(stop_cnt), 32'd1);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // Address miss: A2, 55
    clear_mon();
    do_start();
    write_byte(8'hA2, ack); chk("miss_ack", 32'(ack), 32'd0);
    write_byte(8'h55, ack);
    do_stop(); tick(10);
    chk("miss_sda_drv", 32'(sda_drv_cnt), 32'd0);
    chk("miss_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("miss_busy", 32'(busy_cnt), 32'd0);
    chk("miss_stop", 32'(stop_cnt), 32'd1);

    // Read two bytes: 5A (ACK), C3 (NACK)
    clear_mon();
    tx_q[0] = 8'h5A; tx_q[1] = 8'hC3; tx_idx = 2'd0; tx_vld = 1'b1;
    do_start();
    write_byte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'h5A);
    read_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'hC3);
    tick(8);
    chk("rd_wait_stop_busy", 32'(busy), 32'd0);
    chk("rd_sda_released", 32'(i2c_sda_t), 32'd0);
    do_stop(); tick(10);
    chk("rd_tx_rd_cnt", 32'(tx_rd_cnt), 32'd2);
    chk("rd_stop", 32'(stop_cnt), 32'd1);
    tx_vld = 1'b0;

    // Repeated START: write 10, rSTART, read E7 with NACK
    clear_mon();
    tx_q[0] = 8'hE7; tx_idx = 2'd0; tx_vld = 1'b1;
    do_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    do_rstart();
    write_byte(8'hA1, ack); chk("rs_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d); chk("rs_rdata", 32'(d), 32'hE7);
    do_stop(); tick(10);
    chk("rs_rx_cnt", 32'(rx_cnt), 32'd1);
    chk("rs_rx0", 32'({rx_log_f[0], rx_log_d[0]}), 32'h110);
    chk("rs_tx_rd_cnt", 32'(tx_rd_cnt), 32'd1);
    tx_vld = 1'b0;

    // Underflow: tx_vld low for 200 clk, then 77
    clear_mon();
    tx_q[0] = 8'h77; tx_idx = 2'd0; tx_vld = 1'b0;
    do_start();
    write_byte(8'hA1, ack); chk("uf_addr_ack", 32'(ack), 32'd1);
    fork
      read_byte(1'b1, d);
      begin
        tick(200);
        tx_vld = 1'b1;
      end
    join
    do_stop(); tick(10);
    tx_vld = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    chk("uf_rdata", 32'(d), 32'h77);
    chk("uf_tx_rd_cnt", 32'(tx_rd_cnt), 32'd1);
    chk("uf_stretch_len", 32'(scl_drv_cnt > 150), 32'd1);
`else
    chk("uf_rdata", 32'(d), 32'hFF);
    chk("uf_tx_rd_cnt", 32'(tx_rd_cnt), 32'd0);
    chk("uf_no_stretch", 32'(scl_drv_cnt), 32'd0);
`endif

    // Reset after 4 bits of a read byte (96 = 1001_0110)
    clear_mon();
    tx_q[0] = 8'h96; tx_idx = 2'd0; tx_vld = 1'b1;
    do_start();
    write_byte(8'hA1, ack);
    nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      bit_io(1'b1, s);
      nib = {nib[2:0], s};
    end
    chk("mr_nibble", 32'(nib), 32'h9);
    tick(Q);
    chk("mr_sda_before", 32'(i2c_sda_t), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_sda_rst", 32'(i2c_sda_t), 32'd0);
    chk("mr_scl_rst", 32'(i2c_scl_t), 32'd0);
    tick(3);
    rst = 1'b0;
    tx_vld = 1'b0;
    clear_mon();
    for (int i = 0; i < 4; i++) bit_io(1'b1, s);
    bit_io(1'b0, s);
    chk("mr_ignore_sda", 32'(sda_drv_cnt), 32'd0);
    chk("mr_ignore_busy", 32'(busy_cnt), 32'd0);
    chk("mr_ignore_rx", 32'(rx_cnt), 32'd0);
    do_stop(); tick(10);
    do_start();
    write_byte(8'hA0, ack); chk("mr_recover_ack", 32'(ack), 32'd1);
    do_stop(); tick(10);
    chk("mr_recover_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
